clk_gate_ctrl: RTL and testbench
================================

Name: clk_gate_ctrl

Overview:
- Per-domain clock-gate sequencer. Drives the `en_i` pins of up to NUM_DOMAINS `tc_clk_gating` cells from one free-running (ungated) clock.
- Grants each domain's clock on request through a req/ack handshake, with a fixed wake-up settling delay.
- Gates the clock off again only after a programmable idle hysteresis.
- Sits in the always-on power/clock manager, next to the gating cells it controls.

Parameters:
- NUM_DOMAINS, 4, number of independently gated clock domains (1..32).
- WAKE_CYCLES, 4, cycles from en_o rising to ack_o rising (>=1).
- IDLE_CYCLES, 16, consecutive idle cycles in IDLE before en_o falls (>=1).

Ports:
- clk_i  in  1  free-running (ungated) clock; all logic is on its rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- test_en_i  in  1  scan/test override; forces every en_o high.
- req_i  in  NUM_DOMAINS  per-domain clock request (level).
- force_en_i  in  NUM_DOMAINS  software force-on (CSR level); treated as a held request.
- busy_i  in  NUM_DOMAINS  domain activity; keeps the clock on but never wakes a domain.
- en_o  out  NUM_DOMAINS  gate enable to the tc_clk_gating en_i pins.
- ack_o  out  NUM_DOMAINS  clock running and stable.
- any_on_o  out  1  OR of the registered enables (excludes test_en_i).

Behaviour:
- One independent FSM per domain, states OFF, WAKE, ON, IDLE, plus one down-counter per domain.
- Counter width: $clog2(max(WAKE_CYCLES, IDLE_CYCLES)+1).
- Definitions: wake_d = req_i[d] | force_en_i[d]; keep_d = wake_d | busy_i[d].
- Reset (async assert, synchronous release): all FSMs to OFF, counters 0, en_q = 0, ack_o = 0, any_on_o = 0. en_o = test_en_i during reset.
- OFF:
  - en_q = 0, ack = 0.
  - wake_d -> WAKE, counter <= WAKE_CYCLES-1.
  - busy_i alone does nothing.
- WAKE:
  - en_q = 1, ack = 0.
  - counter == 0 -> ON; else decrement.
  - A request dropping mid-wake does not abort; WAKE always completes to ON.
- ON:
  - en_q = 1, ack = 1.
  - !keep_d -> IDLE, counter <= IDLE_CYCLES-1.
- IDLE:
  - en_q = 1, ack = 1 (clock still running).
  - keep_d -> ON (counter discarded).
  - Else counter == 0 -> OFF; else decrement.
- Outputs are derived from registered state; no combinational path from req/busy to en_o or ack_o.
- en_o[d] = en_q[d] | test_en_i. test_en_i does not alter FSMs, counters, ack_o or any_on_o.
- Latency:
  - req rising, sampled at edge k -> en_o high after edge k.
  - ack_o high after edge k+WAKE_CYCLES.
- Deassert:
  - Last keep_d low sampled at edge k -> state IDLE after edge k.
  - en_o and ack_o fall after edge k+IDLE_CYCLES.
  - An idle keep_d always yields exactly IDLE_CYCLES cycles in IDLE.
- Simultaneous events:
  - keep_d high on the cycle the IDLE counter reaches 0 -> ON wins (clock stays on).
  - wake_d high on the same cycle IDLE goes to OFF is not possible; that case is covered by the rule above.
  - In OFF, wake_d is sampled normally; there is no minimum off time.
- Domains are fully independent; no arbitration or limit on concurrent enables.
- Reset mid-WAKE or mid-IDLE: immediate OFF, en_o drops asynchronously (glitch acceptable, since the gated domain is also in reset).

Test Plan (NUM_DOMAINS=2, WAKE_CYCLES=4, IDLE_CYCLES=8):
- Reset with test_en_i=0 -> en_o=2'b00, ack_o=2'b00, any_on_o=0. Set test_en_i=1 -> en_o=2'b11 immediately, ack_o stays 2'b00.
- req_i[0] high at edge 10 -> en_o[0]=1 after edge 10, ack_o[0]=1 after edge 14. Drop req at edge 20 -> en_o[0] and ack_o[0] fall after edge 28.
- req_i[1] pulsed for 1 cycle at edge 5 -> full wake: ack_o[1]=1 after edge 9. With no keep, ack_o[1] and en_o[1] fall after edge 18.
- Domain 0 in IDLE, busy_i[0] pulsed high when the counter = 0 -> returns to ON; en_o[0] stays 1. Then 8 idle cycles -> OFF.
- busy_i[0]=1 with domain OFF for 20 cycles -> en_o[0] stays 0.
- force_en_i[1]=1 and req_i[0]=1 together, then rst_ni low mid-WAKE -> both en_o bits 0 asynchronously, ack_o=0. After release with inputs held -> both re-wake, ack_o after 4 cycles.

Source files
------------

// File: rtl/clk_gate_ctrl.sv
// Per-domain clock-gate sequencer: req/ack wake-up with fixed settling delay and
// idle hysteresis before the gate enable is dropped. Runs on the free-running clock.
module clk_gate_ctrl #(
  parameter int NUM_DOMAINS = 4,
  parameter int WAKE_CYCLES = 4,
  parameter int IDLE_CYCLES = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   test_en_i,
  input  logic [NUM_DOMAINS-1:0] req_i,
  input  logic [NUM_DOMAINS-1:0] force_en_i,
  input  logic [NUM_DOMAINS-1:0] busy_i,
  output logic [NUM_DOMAINS-1:0] en_o,
  output logic [NUM_DOMAINS-1:0] ack_o,
  output logic                   any_on_o
);

  localparam int MAX_CYCLES = (WAKE_CYCLES > IDLE_CYCLES) ? WAKE_CYCLES : IDLE_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] WAKE_LOAD = CW'(WAKE_CYCLES - 1);
  localparam logic [CW-1:0] IDLE_LOAD = CW'(IDLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_OFF,
    S_WAKE,
    S_ON,
    S_IDLE
  } state_e;

  state_e                 r_state [NUM_DOMAINS];
  logic [CW-1:0]          r_cnt   [NUM_DOMAINS];
  logic [NUM_DOMAINS-1:0] r_en;
  logic [NUM_DOMAINS-1:0] r_ack;

  logic [NUM_DOMAINS-1:0] w_wake;
  logic [NUM_DOMAINS-1:0] w_keep;

  // busy only holds a running clock; it never starts a wake-up on its own
  assign w_wake = req_i | force_en_i;
  assign w_keep = w_wake | busy_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int d = 0; d < NUM_DOMAINS; d++) begin
        r_state[d] <= S_OFF;
        r_cnt[d]   <= '0;
      end
      r_en  <= '0;
      r_ack <= '0;
    end else begin
      for (int d = 0; d < NUM_DOMAINS; d++) begin
        case (r_state[d])
          S_OFF: begin
            if (w_wake[d]) begin
              r_state[d] <= S_WAKE;
              r_cnt[d]   <= WAKE_LOAD;
              r_en[d]    <= 1'b1;
            end
          end
          // a wake-up always runs to completion even if the request vanishes
          S_WAKE: begin
            if (r_cnt[d] == '0) begin
              r_state[d] <= S_ON;
              r_ack[d]   <= 1'b1;
            end else begin
              r_cnt[d] <= r_cnt[d] - CW'(1);
            end
          end
          S_ON: begin
            if (!w_keep[d]) begin
              r_state[d] <= S_IDLE;
              r_cnt[d]   <= IDLE_LOAD;
            end
          end
          // renewed activity beats an expiring counter, so the clock never blips off
          S_IDLE: begin
            if (w_keep[d]) begin
              r_state[d] <= S_ON;
            end else if (r_cnt[d] == '0) begin
              r_state[d] <= S_OFF;
              r_en[d]    <= 1'b0;
              r_ack[d]   <= 1'b0;
            end else begin
              r_cnt[d] <= r_cnt[d] - CW'(1);
            end
          end
          default: begin
            r_state[d] <= S_OFF;
            r_cnt[d]   <= '0;
            r_en[d]    <= 1'b0;
            r_ack[d]   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign en_o     = r_en | {NUM_DOMAINS{test_en_i}};
  assign ack_o    = r_ack;
  assign any_on_o = |r_en;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Self-checking bench for clk_gate_ctrl: directed vector table, hand-written corner
// sequences, and randomized traffic compared against a cycle-count reference model.
module tb_clk_gate_ctrl;

  localparam int N = 2;
  localparam int W = 4;
  localparam int I = 8;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         test_en_i;
  logic [N-1:0] req_i;
  logic [N-1:0] force_en_i;
  logic [N-1:0] busy_i;
  logic [N-1:0] en_o;
  logic [N-1:0] ack_o;
  logic         any_on_o;

  int vecCount  = 0;
  int missCount = 0;

  clk_gate_ctrl #(
    .NUM_DOMAINS(N),
    .WAKE_CYCLES(W),
    .IDLE_CYCLES(I)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .test_en_i (test_en_i),
    .req_i     (req_i),
    .force_en_i(force_en_i),
    .busy_i    (busy_i),
    .en_o      (en_o),
    .ack_o     (ack_o),
    .any_on_o  (any_on_o)
  );

  always #5 clk_i = ~clk_i;

  // reference model: a domain is either off, waking (cycles left), or running
  // with a count of consecutive cycles that had no keep-alive
  bit mOn       [N];
  bit mAck      [N];
  int mWakeLeft [N];
  int mIdleRun  [N];

  task automatic modelReset();
    for (int d = 0; d < N; d++) begin
      mOn[d] = 0; mAck[d] = 0; mWakeLeft[d] = 0; mIdleRun[d] = 0;
    end
  endtask

  task automatic modelStep();
    for (int d = 0; d < N; d++) begin
      bit wake = req_i[d] | force_en_i[d];
      bit keep = wake | busy_i[d];
      if (!mOn[d]) begin
        if (wake) begin
          mOn[d] = 1;
          mWakeLeft[d] = W;
        end
      end else if (!mAck[d]) begin
        mWakeLeft[d]--;
        if (mWakeLeft[d] == 0) begin
          mAck[d] = 1;
          mIdleRun[d] = 0;
        end
      end else begin
        mIdleRun[d] = keep ? 0 : mIdleRun[d] + 1;
        if (mIdleRun[d] > I) begin
          mOn[d] = 0;
          mAck[d] = 0;
        end
      end
    end
  endtask

  function automatic logic [N-1:0] modelEn();
    logic [N-1:0] v;
    for (int d = 0; d < N; d++) v[d] = mOn[d] | test_en_i;
    return v;
  endfunction

  function automatic logic [N-1:0] modelAck();
    logic [N-1:0] v;
    for (int d = 0; d < N; d++) v[d] = mAck[d];
    return v;
  endfunction

  function automatic logic modelAny();
    logic v = 1'b0;
    for (int d = 0; d < N; d++) v = v | mOn[d];
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) begin
      @(posedge clk_i);
      modelStep();
      @(negedge clk_i);
    end
  endtask

  task automatic doReset();
    rst_ni = 1'b0;
    test_en_i = 1'b0; req_i = '0; force_en_i = '0; busy_i = '0;
    modelReset();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] frc;
    logic [N-1:0] busy;
    logic         tst;
    int           cycles;
    logic [N-1:0] expEn;
    logic [N-1:0] expAck;
    logic         expAny;
  } vec_t;

  vec_t vecs [12];

  initial begin
    // each entry: inputs held for 'cycles' edges, then outputs checked
    vecs[0]  = '{2'b01, 2'b00, 2'b00, 1'b0, 1,  2'b01, 2'b00, 1'b1};
    vecs[1]  = '{2'b01, 2'b00, 2'b00, 1'b0, 3,  2'b01, 2'b00, 1'b1};
    vecs[2]  = '{2'b01, 2'b00, 2'b00, 1'b0, 1,  2'b01, 2'b01, 1'b1};
    vecs[3]  = '{2'b00, 2'b00, 2'b01, 1'b0, 5,  2'b01, 2'b01, 1'b1};
    vecs[4]  = '{2'b00, 2'b00, 2'b00, 1'b0, 8,  2'b01, 2'b01, 1'b1};
    vecs[5]  = '{2'b00, 2'b00, 2'b00, 1'b0, 1,  2'b00, 2'b00, 1'b0};
    vecs[6]  = '{2'b00, 2'b00, 2'b10, 1'b0, 20, 2'b00, 2'b00, 1'b0};
    vecs[7]  = '{2'b00, 2'b10, 2'b00, 1'b1, 1,  2'b11, 2'b00, 1'b1};
    vecs[8]  = '{2'b00, 2'b00, 2'b00, 1'b0, 4,  2'b10, 2'b10, 1'b1};
    vecs[9]  = '{2'b00, 2'b00, 2'b00, 1'b0, 8,  2'b10, 2'b10, 1'b1};
    vecs[10] = '{2'b00, 2'b00, 2'b00, 1'b0, 1,  2'b00, 2'b00, 1'b0};
    vecs[11] = '{2'b00, 2'b00, 2'b00, 1'b1, 1,  2'b11, 2'b00, 1'b0};

    rst_ni = 1'b0;
    test_en_i = 1'b0; req_i = '0; force_en_i = '0; busy_i = '0;
    modelReset();
    repeat (2) @(negedge clk_i);
    checkOutput("reset en_o", en_o, 2'b00);
    checkOutput("reset ack_o", ack_o, 2'b00);
    checkOutput("reset any_on_o", any_on_o, 1'b0);
    test_en_i = 1'b1;
    #1;
    checkOutput("reset test_en en_o", en_o, 2'b11);
    checkOutput("reset test_en ack_o", ack_o, 2'b00);
    @(negedge clk_i);
    test_en_i = 1'b0;
    rst_ni = 1'b1;

    for (int v = 0; v < 12; v++) begin
      req_i = vecs[v].req; force_en_i = vecs[v].frc;
      busy_i = vecs[v].busy; test_en_i = vecs[v].tst;
      applyStimulus(vecs[v].cycles);
      checkOutput($sformatf("vec%0d en_o", v), en_o, vecs[v].expEn);
      checkOutput($sformatf("vec%0d ack_o", v), ack_o, vecs[v].expAck);
      checkOutput($sformatf("vec%0d any_on_o", v), any_on_o, vecs[v].expAny);
    end
    test_en_i = 1'b0;

    // keep-alive arriving exactly when the idle counter has run out
    req_i = 2'b01;
    applyStimulus(5);
    checkOutput("idle0 woke ack", ack_o, 2'b01);
    req_i = 2'b00;
    applyStimulus(I);
    checkOutput("idle0 pre-busy en", en_o, 2'b01);
    busy_i = 2'b01;
    applyStimulus(1);
    checkOutput("idle0 busy wins en", en_o, 2'b01);
    checkOutput("idle0 busy wins ack", ack_o, 2'b01);
    busy_i = 2'b00;
    applyStimulus(I);
    checkOutput("idle0 hysteresis en", en_o, 2'b01);
    applyStimulus(1);
    checkOutput("idle0 off en", en_o, 2'b00);
    checkOutput("idle0 off ack", ack_o, 2'b00);

    // reset in the middle of a wake-up, then re-wake with inputs held
    force_en_i = 2'b10; req_i = 2'b01;
    applyStimulus(2);
    checkOutput("midwake en", en_o, 2'b11);
    #2 rst_ni = 1'b0;
    #1;
    checkOutput("midwake reset en", en_o, 2'b00);
    checkOutput("midwake reset ack", ack_o, 2'b00);
    checkOutput("midwake reset any", any_on_o, 1'b0);
    modelReset();
    @(negedge clk_i);
    rst_ni = 1'b1;
    applyStimulus(1);
    checkOutput("rewake en", en_o, 2'b11);
    applyStimulus(W - 1);
    checkOutput("rewake ack early", ack_o, 2'b00);
    applyStimulus(1);
    checkOutput("rewake ack", ack_o, 2'b11);

    // randomized traffic against the reference model
    doReset();
    for (int c = 0; c < 2000; c++) begin
      for (int d = 0; d < N; d++) begin
        if ($urandom_range(0, 7) == 0)  req_i[d] = ~req_i[d];
        if ($urandom_range(0, 39) == 0) force_en_i[d] = ~force_en_i[d];
        if ($urandom_range(0, 5) == 0)  busy_i[d] = ~busy_i[d];
      end
      test_en_i = ($urandom_range(0, 29) == 0);
      applyStimulus(1);
      checkOutput("rand en_o", en_o, modelEn());
      checkOutput("rand ack_o", ack_o, modelAck());
      checkOutput("rand any_on_o", any_on_o, modelAny());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
